// File: rtl/multdiv_stall_ctrl.sv
// Issue/stall controller for the multicycle mult/div unit; optional BUSY watchdog via MD_TIMEOUT_EN.
// Latency: start pulse 1 cycle after detect; result beat 1 cycle after data_resultRDY.
// Backpressure: stall freezes F/D/X from the detect cycle until the RDY cycle, inclusive.
`timescale 1ns/1ps
module multdiv_stall_ctrl #(
  parameter int STATUS_MULT    = 4,
  parameter int STATUS_DIV     = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DX_IR,
  input  logic [31:0] dx_operandA,
  input  logic [31:0] dx_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        md_valid,
  output logic        md_we,
  output logic [4:0]  md_rd,
  output logic [31:0] md_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  localparam logic [4:0]  OPC_ALU  = 5'b00000;
  localparam logic [4:0]  ALU_MULT = 5'b00110;
  localparam logic [4:0]  ALU_DIV  = 5'b00111;
  localparam logic [4:0]  RD_EXC   = 5'd30;

  state_t     state, state_nxt;
  logic       is_mult, is_div, is_md;
  logic       op_div;
  logic [4:0] rd_q;
  logic       timeout;
  logic       finish;
  logic       unused_ir;

  assign is_mult = (DX_IR[31:27] == OPC_ALU) && (DX_IR[6:2] == ALU_MULT);
  assign is_div  = (DX_IR[31:27] == OPC_ALU) && (DX_IR[6:2] == ALU_DIV);
  assign is_md   = is_mult | is_div;
  assign unused_ir = ^{DX_IR[21:7], DX_IR[1:0]};

`ifdef MD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Cleared while in ISSUE so it reads zero on the first BUSY cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign finish = (state == BUSY) && (data_resultRDY || timeout);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    case (state)
      IDLE: begin
        if (is_md) begin
          stall     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        stall     = 1'b1;
        ctrl_MULT = ~op_div;
        ctrl_DIV  = op_div;
        state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (finish) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Reset holds state at IDLE, but a mult/div sitting in X must not stall a flushed pipe.
    if (!reset) begin
      stall = 1'b0;
    end
  end

  assign md_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_operandA <= '0;
      md_operandB <= '0;
      rd_q        <= '0;
      op_div      <= 1'b0;
    end else if ((state == IDLE) && is_md) begin
      md_operandA <= dx_operandA;
      md_operandB <= dx_operandB;
      rd_q        <= DX_IR[26:22];
      op_div      <= is_div;
    end
  end

  // A real strobe wins over a coincident watchdog expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_rd     <= '0;
      md_result <= '0;
      md_we     <= 1'b0;
    end else if (finish) begin
      if (data_resultRDY && !data_exception) begin
        md_rd     <= rd_q;
        md_result <= data_result;
        md_we     <= |rd_q;
      end else begin
        md_rd     <= RD_EXC;
        md_result <= op_div ? 32'(STATUS_DIV) : 32'(STATUS_MULT);
        md_we     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl: scoreboard of expected writeback beats.
`timescale 1ns/1ps
module tb_multdiv_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DX_IR, dx_operandA, dx_operandB, data_result;
  logic        data_exception, data_resultRDY;
  logic        ctrl_MULT, ctrl_DIV, stall, md_valid, md_we;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic [4:0]  md_rd;

  always #5 clock = ~clock;

  multdiv_stall_ctrl #(.STATUS_MULT(4), .STATUS_DIV(5), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .DX_IR(DX_IR),
    .dx_operandA(dx_operandA), .dx_operandB(dx_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .stall(stall),
    .md_valid(md_valid), .md_we(md_we), .md_rd(md_rd), .md_result(md_result)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int mult_pulses = 0;
  int div_pulses = 0;

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] res, input logic we);
    exp_t e;
    e.rd = rd; e.res = res; e.we = we;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic settle();
    #2;
  endtask

  // Writeback monitor: every md_valid beat must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (ctrl_MULT === 1'b1) mult_pulses++;
      if (ctrl_DIV === 1'b1) div_pulses++;
      if (ctrl_MULT || ctrl_DIV) chk("ctrl_exclusive", {31'b0, ctrl_MULT & ctrl_DIV}, 32'd0);
      if (md_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_md_valid: observed md_valid=1 rd=%0d result=0x%0h, required no beat", md_rd, md_result);
        end else begin
          e = exp_q.pop_front();
          chk("wb_md_rd", 32'(md_rd), 32'(e.rd));
          chk("wb_md_result", md_result, e.res);
          chk("wb_md_we", 32'(md_we), 32'(e.we));
        end
      end
    end
  end

  // One full mult/div transaction starting in the current (detect) cycle; ends in the cycle after DONE.
  task automatic run_md(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] res, input logic exc,
                        input exp_t expv, input bit isdiv, output int issue_cyc);
    int stalls;
    int mp0;
    int dp0;
    stalls = 0;
    mp0 = mult_pulses;
    dp0 = div_pulses;
    exp_q.push_back(expv);
    DX_IR = ir; dx_operandA = a; dx_operandB = b;
    settle();
    chk("detect_stall", 32'(stall), 32'd1);
    if (stall) stalls++;
    next();
    issue_cyc = cyc_n;
    dx_operandA = ~a; dx_operandB = ~b;
    data_resultRDY = 1'b1; data_result = 32'hBAD0BAD0; data_exception = 1'b1;
    settle();
    chk("issue_ctrl_MULT", 32'(ctrl_MULT), 32'(!isdiv));
    chk("issue_ctrl_DIV", 32'(ctrl_DIV), 32'(isdiv));
    chk("issue_operandA", md_operandA, a);
    chk("issue_operandB", md_operandB, b);
    if (stall) stalls++;
    next();
    data_resultRDY = 1'b0; data_exception = 1'b0; data_result = '0;
    for (int i = 1; i < lat; i++) begin
      settle();
      if (stall) stalls++;
      next();
    end
    data_resultRDY = 1'b1; data_result = res; data_exception = exc;
    settle();
    if (stall) stalls++;
    next();
    data_resultRDY = 1'b0; data_result = '0; data_exception = 1'b0;
    settle();
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_md_valid", 32'(md_valid), 32'd1);
    if (stall) stalls++;
    chk("stall_cycles", stalls, lat + 2);
    chk("mult_pulse_count", mult_pulses - mp0, isdiv ? 0 : 1);
    chk("div_pulse_count", div_pulses - dp0, isdiv ? 1 : 0);
    next();
    DX_IR = '0;
  endtask

  initial begin
    int ic1;
    int ic2;
    reset = 1'b0;
    DX_IR = '0; dx_operandA = '0; dx_operandB = '0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
    repeat (3) next();
    settle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_md_valid", 32'(md_valid), 32'd0);
    chk("rst_ctrl", {30'b0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("rst_md_result", md_result, 32'd0);
    chk("rst_md_rd", 32'(md_rd), 32'd0);
    chk("rst_md_we", 32'(md_we), 32'd0);
    chk("rst_operandA", md_operandA, 32'd0);
    next();
    reset = 1'b1;
    next();

    // Spurious strobe while idle
    data_resultRDY = 1'b1; data_result = 32'h1234; data_exception = 1'b1;
    settle();
    chk("idle_rdy_stall", 32'(stall), 32'd0);
    next();
    data_resultRDY = 1'b0; data_result = '0; data_exception = 1'b0;
    settle();
    chk("idle_rdy_no_valid", 32'(md_valid), 32'd0);
    chk("idle_rdy_md_rd", 32'(md_rd), 32'd0);
    next();

    run_md(32'h00C22018, 32'd6, 32'd7, 33, 32'd42, 1'b0, mk(5'd3, 32'd42, 1'b1), 1'b0, ic1);
    settle();
    chk("operandA_held", md_operandA, 32'd6);
    chk("operandB_held", md_operandB, 32'd7);
    chk("idle_after_done", 32'(stall), 32'd0);
    next();

    run_md(32'h00C2201C, 32'd100, 32'd0, 5, 32'd0, 1'b1, mk(5'd30, 32'd5, 1'b1), 1'b1, ic1);
    run_md(32'h0140001C, 32'd100, 32'd7, 3, 32'd14, 1'b0, mk(5'd5, 32'd14, 1'b1), 1'b1, ic1);
    run_md(32'h00C22018, 32'h7FFFFFFF, 32'd2, 4, 32'd0, 1'b1, mk(5'd30, 32'd4, 1'b1), 1'b0, ic1);
    run_md(32'h00022018, 32'd3, 32'd5, 2, 32'd15, 1'b0, mk(5'd0, 32'd15, 1'b0), 1'b0, ic1);
    next();

    // Back-to-back: second mult enters X right after DONE
    run_md(32'h00C22018, 32'd2, 32'd3, 2, 32'd6, 1'b0, mk(5'd3, 32'd6, 1'b1), 1'b0, ic1);
    run_md(32'h01022018, 32'd4, 32'd5, 1, 32'd20, 1'b0, mk(5'd4, 32'd20, 1'b1), 1'b0, ic2);
    chk("b2b_issue_gap", ic2 - ic1, 5);
    next();

    // Reset during BUSY, then a late strobe
    DX_IR = 32'h00C22018; dx_operandA = 32'd9; dx_operandB = 32'd9;
    next(); next(); next();
    settle();
    chk("busy_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_valid", 32'(md_valid), 32'd0);
    DX_IR = '0;
    next(); next();
    reset = 1'b1;
    next();
    data_resultRDY = 1'b1; data_result = 32'h77; data_exception = 1'b0;
    settle();
    chk("late_rdy_stall", 32'(stall), 32'd0);
    next();
    data_resultRDY = 1'b0; data_result = '0;
    settle();
    chk("late_rdy_no_valid", 32'(md_valid), 32'd0);
    chk("late_rdy_result", md_result, 32'd0);
    chk("late_rdy_ctrl", {30'b0, ctrl_MULT, ctrl_DIV}, 32'd0);
    next();

`ifdef MD_TIMEOUT_EN
    begin
      int b0;
      bit seen;
      seen = 1'b0;
      exp_q.push_back(mk(5'd30, 32'd4, 1'b1));
      DX_IR = 32'h00C22018; dx_operandA = 32'd1; dx_operandB = 32'd1;
      next();
      next();
      b0 = cyc_n;
      for (int i = 0; i < 200 && !seen; i++) begin
        settle();
        if (md_valid) seen = 1'b1;
        else next();
      end
      chk("timeout_seen", 32'(seen), 32'd1);
      chk("timeout_latency", cyc_n - b0, 64);
      next();
      DX_IR = '0;
      next();
    end
`else
    run_md(32'h00C22018, 32'd11, 32'd11, 100, 32'd121, 1'b0, mk(5'd3, 32'd121, 1'b1), 1'b0, ic1);
    next();
`endif

    repeat (3) next();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
